// File: rtl/top_k_pkg.sv
// Shared types and helpers for the streaming top-K selector.
// Optional arrival-index tracking is enabled with TOP_K_INDEX_EN.
package top_k_pkg;

    localparam int IDX_W = 16;
    localparam int MAX_W = 64;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    function automatic int cnt_width(input int k);
        return $clog2(k + 1);
    endfunction

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    function automatic logic beats(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int               w,
        input bit               sgn,
        input bit               dsc
    );
        logic [MAX_W-1:0] sb;
        logic [MAX_W-1:0] ax;
        logic [MAX_W-1:0] bx;
        sb = 64'd1 << (w - 1);
        ax = sgn ? (a ^ sb) : a;
        bx = sgn ? (b ^ sb) : b;
        return dsc ? (ax > bx) : (ax < bx);
    endfunction

endpackage

// File: rtl/top_k_cell.sv
// One slot of the insertion-sorted array: value, valid flag, optional index.
// Optional arrival-index storage is enabled with TOP_K_INDEX_EN.
module top_k_cell
    import top_k_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SIGNED_CMP = 0,
    parameter int DESCEND    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] new_val,
    input  logic [DATA_W-1:0] up_val,
    input  logic              up_vld,
    input  logic              up_beat,
`ifdef TOP_K_INDEX_EN
    input  logic [IDX_W-1:0]  new_idx,
    input  logic [IDX_W-1:0]  up_idx,
    output logic [IDX_W-1:0]  nxt_idx,
    output logic [IDX_W-1:0]  idx,
`endif
    output logic              beat,
    output logic [DATA_W-1:0] nxt_val,
    output logic              nxt_vld,
    output logic [DATA_W-1:0] val,
    output logic              vld
);

    assign beat = !vld || beats(64'(new_val), 64'(val), DATA_W,
                                SIGNED_CMP != 0, DESCEND != 0);

    always_comb begin
        nxt_val = val;
        nxt_vld = vld;
`ifdef TOP_K_INDEX_EN
        nxt_idx = idx;
`endif
        if (load) begin
            if (up_beat) begin
                nxt_val = up_val;
                nxt_vld = up_vld;
`ifdef TOP_K_INDEX_EN
                nxt_idx = up_idx;
`endif
            end else if (beat) begin
                nxt_val = new_val;
                nxt_vld = 1'b1;
`ifdef TOP_K_INDEX_EN
                nxt_idx = new_idx;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
            vld <= 1'b0;
`ifdef TOP_K_INDEX_EN
            idx <= '0;
`endif
        end else if (flush) begin
            val <= '0;
            vld <= 1'b0;
`ifdef TOP_K_INDEX_EN
            idx <= '0;
`endif
        end else begin
            val <= nxt_val;
            vld <= nxt_vld;
`ifdef TOP_K_INDEX_EN
            idx <= nxt_idx;
`endif
        end
    end

endmodule

// File: rtl/top_k_stream.sv
// Streaming top-K selector: sorted insertion per beat, result per TLAST.
// Define TOP_K_INDEX_EN to also report per-slot arrival indices.
module top_k_stream
    import top_k_pkg::*;
#(
    parameter int K          = 16,
    parameter int DATA_W     = 32,
    parameter int OUT_W      = 512,
    parameter int SIGNED_CMP = 0,
    parameter int DESCEND    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    rx_data_TVALID,
    output logic                    rx_data_TREADY,
    input  logic [DATA_W-1:0]       rx_data_TDATA,
    input  logic                    rx_data_TLAST,
    output logic                    tx_data_TVALID,
    input  logic                    tx_data_TREADY,
    output logic [OUT_W-1:0]        tx_data_TDATA,
`ifdef TOP_K_INDEX_EN
    output logic [IDX_W*K-1:0]      tx_index,
`endif
    output logic [cnt_width(K)-1:0] tx_count
);

    localparam int CW = cnt_width(K);

    if (K < 1 || K * DATA_W > OUT_W || DATA_W > MAX_W) begin : g_bad_cfg
        $error("top_k_stream: illegal K/DATA_W/OUT_W combination");
    end

    state_t state;

    logic accept;
    logic done;
    logic flush;

    assign rx_data_TREADY = !tx_data_TVALID || tx_data_TREADY;
    assign accept = rx_data_TVALID && rx_data_TREADY;
    assign done   = accept && rx_data_TLAST && !clear;
    assign flush  = clear || done;

    logic [DATA_W-1:0] val     [K];
    logic [DATA_W-1:0] nxt_val [K];
    logic              vld     [K];
    logic              nxt_vld [K];
    logic              beat    [K];

`ifdef TOP_K_INDEX_EN
    logic [IDX_W-1:0] idx     [K];
    logic [IDX_W-1:0] nxt_idx [K];
    logic [IDX_W-1:0] arr_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_idx <= '0;
        end else if (flush) begin
            arr_idx <= '0;
        end else if (accept && arr_idx != '1) begin
            arr_idx <= arr_idx + 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < K; i++) begin : g_cell
        logic [DATA_W-1:0] up_val;
        logic              up_vld;
        logic              up_beat;
`ifdef TOP_K_INDEX_EN
        logic [IDX_W-1:0]  up_idx;
`endif
        if (i == 0) begin : g_head
            assign up_val  = '0;
            assign up_vld  = 1'b0;
            assign up_beat = 1'b0;
`ifdef TOP_K_INDEX_EN
            assign up_idx  = '0;
`endif
        end else begin : g_link
            assign up_val  = val[i-1];
            assign up_vld  = vld[i-1];
            assign up_beat = beat[i-1];
`ifdef TOP_K_INDEX_EN
            assign up_idx  = idx[i-1];
`endif
        end

        top_k_cell #(
            .DATA_W    (DATA_W),
            .SIGNED_CMP(SIGNED_CMP),
            .DESCEND   (DESCEND)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (flush),
            .load   (accept),
            .new_val(rx_data_TDATA),
            .up_val (up_val),
            .up_vld (up_vld),
            .up_beat(up_beat),
`ifdef TOP_K_INDEX_EN
            .new_idx(arr_idx),
            .up_idx (up_idx),
            .nxt_idx(nxt_idx[i]),
            .idx    (idx[i]),
`endif
            .beat   (beat[i]),
            .nxt_val(nxt_val[i]),
            .nxt_vld(nxt_vld[i]),
            .val    (val[i]),
            .vld    (vld[i])
        );
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt = (accept && cnt != CW'(K)) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Result is taken from the post-insertion view so the last beat counts.
    logic [OUT_W-1:0] pack_data;
`ifdef TOP_K_INDEX_EN
    logic [IDX_W*K-1:0] pack_idx;
`endif

    always_comb begin
        pack_data = '0;
`ifdef TOP_K_INDEX_EN
        pack_idx = '0;
`endif
        for (int i = 0; i < K; i++) begin
            pack_data[i*DATA_W +: DATA_W] = nxt_vld[i] ? nxt_val[i] : '0;
`ifdef TOP_K_INDEX_EN
            pack_idx[i*IDX_W +: IDX_W] = nxt_vld[i] ? nxt_idx[i] : '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ACCUM;
            tx_data_TVALID <= 1'b0;
            tx_data_TDATA  <= '0;
            tx_count       <= '0;
`ifdef TOP_K_INDEX_EN
            tx_index       <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (done) begin
                        state          <= HOLD;
                        tx_data_TVALID <= 1'b1;
                        tx_data_TDATA  <= pack_data;
                        tx_count       <= cnt_nxt;
`ifdef TOP_K_INDEX_EN
                        tx_index       <= pack_idx;
`endif
                    end
                end
                HOLD: begin
                    if (done) begin
                        tx_data_TVALID <= 1'b1;
                        tx_data_TDATA  <= pack_data;
                        tx_count       <= cnt_nxt;
`ifdef TOP_K_INDEX_EN
                        tx_index       <= pack_idx;
`endif
                    end else if (tx_data_TREADY) begin
                        state          <= ACCUM;
                        tx_data_TVALID <= 1'b0;
                    end
                end
                default: begin
                    state          <= ACCUM;
                    tx_data_TVALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_k_stream.sv
// Self-checking bench for top_k_stream: directed tables, corner sequences,
// and random frames against a sorted-queue reference model.
module tb_top_k_stream;

    localparam int DW  = 32;
    localparam int KA  = 4;
    localparam int OWA = 128;
    localparam int KB  = 3;
    localparam int OWB = 96;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic           a_clear = 1'b0;
    logic           a_rv = 1'b0;
    logic           a_rr;
    logic [DW-1:0]  a_rd = '0;
    logic           a_rl = 1'b0;
    logic           a_tv;
    logic           a_tr = 1'b1;
    logic [OWA-1:0] a_td;
    logic [2:0]     a_tc;

    logic           b_clear = 1'b0;
    logic           b_rv = 1'b0;
    logic           b_rr;
    logic [DW-1:0]  b_rd = '0;
    logic           b_rl = 1'b0;
    logic           b_tv;
    logic           b_tr = 1'b1;
    logic [OWB-1:0] b_td;
    logic [1:0]     b_tc;

    top_k_stream #(
        .K(KA), .DATA_W(DW), .OUT_W(OWA), .SIGNED_CMP(0), .DESCEND(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear),
        .rx_data_TVALID(a_rv), .rx_data_TREADY(a_rr),
        .rx_data_TDATA(a_rd), .rx_data_TLAST(a_rl),
        .tx_data_TVALID(a_tv), .tx_data_TREADY(a_tr),
        .tx_data_TDATA(a_td), .tx_count(a_tc)
    );

    top_k_stream #(
        .K(KB), .DATA_W(DW), .OUT_W(OWB), .SIGNED_CMP(1), .DESCEND(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .rx_data_TVALID(b_rv), .rx_data_TREADY(b_rr),
        .rx_data_TDATA(b_rd), .rx_data_TLAST(b_rl),
        .tx_data_TVALID(b_tv), .tx_data_TREADY(b_tr),
        .tx_data_TDATA(b_td), .tx_count(b_tc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        int              len;
        logic [31:0]     v[8];
        logic [3:0][31:0] slots;
        int              cnt;
    } vec_t;

    typedef struct {
        logic [127:0] d;
        int           c;
    } res_t;

    res_t expq[$];
    bit   mon_en = 0;
    bit   rand_tr = 0;

    always @(negedge clk) begin
        if (mon_en && a_tv && a_tr) begin
            if (expq.size() == 0) begin
                check("rand_unexpected", 1, 0);
            end else begin
                res_t e;
                e = expq.pop_front();
                check("rand_data", a_td, e.d);
                check("rand_count", 128'(a_tc), 128'(e.c));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_tr) begin
            #1;
            a_tr = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one beat; return one ns after the edge that accepted it.
    task automatic send_a(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        a_rv = 1'b1;
        a_rd = d;
        a_rl = l;
        @(negedge clk);
        while (!a_rr && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!a_rr) check("a_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        a_rv = 1'b0;
        a_rl = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        b_rv = 1'b1;
        b_rd = d;
        b_rl = l;
        @(negedge clk);
        while (!b_rr && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!b_rr) check("b_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        b_rv = 1'b0;
        b_rl = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[4];
        logic [127:0] exp_d;
        logic [31:0]  fq[$];
        logic [31:0]  sq[$];
        int           len;
        int           n;
        res_t         r;

        tbl[0].len = 5;
        tbl[0].v = '{5, 1, 9, 3, 7, 0, 0, 0};
        tbl[0].slots = {32'd3, 32'd5, 32'd7, 32'd9};
        tbl[0].cnt = 4;
        tbl[1].len = 2;
        tbl[1].v = '{8, 2, 0, 0, 0, 0, 0, 0};
        tbl[1].slots = {32'd0, 32'd0, 32'd2, 32'd8};
        tbl[1].cnt = 2;
        tbl[2].len = 1;
        tbl[2].v = '{6, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].slots = {32'd0, 32'd0, 32'd0, 32'd6};
        tbl[2].cnt = 1;
        tbl[3].len = 3;
        tbl[3].v = '{4, 4, 4, 0, 0, 0, 0, 0};
        tbl[3].slots = {32'd0, 32'd4, 32'd4, 32'd4};
        tbl[3].cnt = 3;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_tvalid", 128'(a_tv), 0);
        check("reset_tdata", a_td, 0);
        check("reset_count", 128'(a_tc), 0);
        check("reset_rready", 128'(a_rr), 1);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < tbl[i].len; j++) begin
                if (j == tbl[i].len - 1)
                    check("tbl_pre_valid", 128'(a_tv), 0);
                send_a(tbl[i].v[j], j == tbl[i].len - 1);
            end
            check("tbl_valid", 128'(a_tv), 1);
            check("tbl_data", a_td, 128'(tbl[i].slots));
            check("tbl_count", 128'(a_tc), 128'(tbl[i].cnt));
            @(posedge clk);
            #1;
            check("tbl_drained", 128'(a_tv), 0);
        end

        // Stall the result, then drain it in the same cycle a new TLAST lands.
        a_tr = 1'b0;
        send_a(10, 0);
        send_a(20, 1);
        a_rv = 1'b1;
        a_rd = 3;
        a_rl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rready", 128'(a_rr), 0);
            check("bp_data", a_td, {32'd0, 32'd0, 32'd10, 32'd20});
            check("bp_count", 128'(a_tc), 2);
        end
        a_tr = 1'b1;
        #1;
        check("bp_release_rready", 128'(a_rr), 1);
        @(posedge clk);
        #1;
        a_rv = 1'b0;
        a_rl = 1'b0;
        check("bp_reload_valid", 128'(a_tv), 1);
        check("bp_reload_data", a_td, {32'd0, 32'd0, 32'd0, 32'd3});
        check("bp_reload_count", 128'(a_tc), 1);
        @(posedge clk);
        #1;
        check("bp_drained", 128'(a_tv), 0);

        send_a(3, 0);
        send_a(9, 0);
        a_clear = 1'b1;
        a_rv = 1'b1;
        a_rd = 100;
        a_rl = 1'b1;
        @(posedge clk);
        #1;
        a_clear = 1'b0;
        a_rv = 1'b0;
        a_rl = 1'b0;
        check("clr_no_result", 128'(a_tv), 0);
        send_a(1, 1);
        check("clr_valid", 128'(a_tv), 1);
        check("clr_data", a_td, {32'd0, 32'd0, 32'd0, 32'd1});
        check("clr_count", 128'(a_tc), 1);
        @(posedge clk);
        #1;

        send_b(32'hFFFF_FFFB, 0);
        send_b(32'd10, 0);
        send_b(32'hFFFF_FFEC, 0);
        send_b(32'd0, 1);
        check("sgn_valid", 128'(b_tv), 1);
        check("sgn_data", 128'(b_td),
              128'({32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFEC}));
        check("sgn_count", 128'(b_tc), 3);

        mon_en = 1;
        rand_tr = 1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 8);
            fq.delete();
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) fq.push_back($urandom);
                else fq.push_back(32'($urandom_range(0, 15)));
            end
            sq = fq;
            sq.rsort();
            exp_d = '0;
            r.c = (len < KA) ? len : KA;
            for (int s = 0; s < r.c; s++) exp_d[s*32 +: 32] = sq[s];
            r.d = exp_d;
            expq.push_back(r);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 5) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_a(fq[j], j == len - 1);
            end
        end
        rand_tr = 0;
        @(posedge clk);
        #2;
        a_tr = 1'b1;
        n = 0;
        while (expq.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("rand_all_drained", 128'(expq.size()), 0);
        mon_en = 0;
        @(posedge clk);
        #1;

        a_tr = 1'b0;
        send_a(5, 1);
        check("hold_valid", 128'(a_tv), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_hold_tvalid", 128'(a_tv), 0);
        check("rst_hold_tdata", a_td, 0);
        check("rst_hold_count", 128'(a_tc), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_tr = 1'b1;
        check("rst_rready", 128'(a_rr), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
